load_extend_unit: RTL and testbench

//   Load-side counterpart of the store data formatter: runs one RV64 load (lb/lh/lw/ld/lbu/lhu/lwu).

---
 rtl/load_extend_unit_if.sv | 21 ++
 rtl/load_extend_unit.sv | 143 ++++++++++++++
 tb/tb_load_extend_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_extend_unit_if.sv
// Data-memory read port shared by load_extend_unit (master) and the memory (slave).
interface load_extend_unit_if;
    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/load_extend_unit.sv
// RV64 load unit: one doubleword read per load, then byte/half/word extraction and extension.
// Optional macro LOAD_MISALIGN_TRAP_EN: misaligned loads fail immediately instead of reading.
module load_extend_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [31:0]               Register_Intruction_Instr31_0,
    input  logic [63:0]               addr,
    load_extend_unit_if.master        mem,
    output logic                      busy,
    output logic                      load_valid,
    output logic [63:0]               load_data,
    output logic                      load_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       funct3_q;
    logic [2:0]       off_q;
    logic [CNT_W-1:0] timeout_count;
    logic             load_start;
    logic [2:0]       funct3_in;
    logic             unused_instr_bits;

    assign funct3_in  = Register_Intruction_Instr31_0[14:12];
    assign load_start = start && (Register_Intruction_Instr31_0[6:0] == 7'd3);
    assign unused_instr_bits = ^{Register_Intruction_Instr31_0[31:15],
                                 Register_Intruction_Instr31_0[11:7]};

    // Offsets below natural alignment are dropped by the half/word shifts.
    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] w);
        logic [63:0] byte_sh;
        logic [63:0] half_sh;
        logic [63:0] word_sh;
        logic [63:0] r;
        byte_sh = w >> {off, 3'b000};
        half_sh = w >> {off[2:1], 4'b0000};
        word_sh = w >> {off[2], 5'b00000};
        case (f3)
            3'd0:    r = {{56{byte_sh[7]}}, byte_sh[7:0]};
            3'd1:    r = {{48{half_sh[15]}}, half_sh[15:0]};
            3'd2:    r = {{32{word_sh[31]}}, word_sh[31:0]};
            3'd4:    r = {56'd0, byte_sh[7:0]};
            3'd5:    r = {48'd0, half_sh[15:0]};
            3'd6:    r = {32'd0, word_sh[31:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        logic m;
        case (f3)
            3'd1, 3'd5: m = off[0];
            3'd2, 3'd6: m = (off[1:0] != 2'b00);
            3'd3:       m = (off != 3'b000);
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

    // Single registered FSM; every output is a flop so the memory port sees clean strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            funct3_q      <= 3'd0;
            off_q         <= 3'd0;
            timeout_count <= '0;
            mem.mem_rd    <= 1'b0;
            mem.mem_addr  <= 64'd0;
            busy          <= 1'b0;
            load_valid    <= 1'b0;
            load_data     <= 64'd0;
            load_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        funct3_q      <= funct3_in;
                        off_q         <= addr[2:0];
                        mem.mem_addr  <= {addr[63:3], 3'b000};
                        timeout_count <= '0;
                        busy          <= 1'b1;
`ifdef LOAD_MISALIGN_TRAP_EN
                        if (misaligned(funct3_in, addr[2:0])) begin
                            state      <= DONE;
                            load_valid <= 1'b1;
                            load_err   <= 1'b1;
                            load_data  <= 64'd0;
                        end else begin
                            state      <= REQ;
                            mem.mem_rd <= 1'b1;
                        end
`else
                        state      <= REQ;
                        mem.mem_rd <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        state      <= DONE;
                        mem.mem_rd <= 1'b0;
                        load_valid <= 1'b1;
                        load_data  <= extend(funct3_q, off_q, mem.mem_rdata);
                        load_err   <= (funct3_q == 3'd7);
                    end else if (timeout_count == TIMEOUT_LAST) begin
                        state      <= DONE;
                        mem.mem_rd <= 1'b0;
                        load_valid <= 1'b1;
                        load_data  <= 64'd0;
                        load_err   <= 1'b1;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    load_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    mem.mem_rd <= 1'b0;
                    load_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_extend_unit.sv
// Self-checking bench for load_extend_unit: directed spec scenarios plus randomized loads
// compared against a byte-level reference model.
module tb_load_extend_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [63:0] addr = 64'd0;
    logic        busy;
    logic        load_valid;
    logic [63:0] load_data;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    load_extend_unit_if mif();

    load_extend_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk                           (clk),
        .reset_n                       (reset_n),
        .start                         (start),
        .Register_Intruction_Instr31_0 (instr),
        .addr                          (addr),
        .mem                           (mif.master),
        .busy                          (busy),
        .load_valid                    (load_valid),
        .load_data                     (load_data),
        .load_err                      (load_err)
    );

    always #5 clk = ~clk;

`ifdef LOAD_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    function automatic logic [31:0] load_instr(input logic [2:0] f3);
        return {17'd0, f3, 5'd1, 7'd3};
    endfunction

    // Reference: pick an access size, round the offset down to it, shift bytes out, extend.
    function automatic void ref_load(input logic [2:0] f3, input logic [63:0] a,
                                     input logic [63:0] w, output logic [63:0] data,
                                     output logic err, output bit trapped);
        int size;
        int off;
        logic [63:0] v;
        logic [63:0] mask;
        size = 1 << int'(f3[1:0]);
        off  = int'(a[2:0]);
        trapped = TRAP_EN && (f3 != 3'd7) && ((off % size) != 0);
        if (trapped) begin
            data = 64'd0;
            err  = 1'b1;
            return;
        end
        off = off - (off % size);
        v = w >> (8 * off);
        if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v = v & mask;
            if (!f3[2] && (((v >> (8 * size - 1)) & 64'd1) == 64'd1))
                v = v | ~mask;
        end
        data = v;
        err  = (f3 == 3'd7);
    endfunction

    // Runs one load from an IDLE cycle, acting as a memory that answers after `delay`
    // wait cycles; returns in IDLE. poke_at re-asserts start at that sample index.
    task automatic do_load(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] w,
                           input int delay, input int poke_at,
                           output bit seen, output logic [63:0] data, output logic err,
                           output logic [63:0] maddr, output int rd_cycles, output int edges,
                           output bit busy_ok);
        start = 1'b1;
        instr = ins;
        addr  = a;
        mif.mem_rdata = w;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        data = 64'd0;
        err = 1'b0;
        rd_cycles = 0;
        edges = 0;
        busy_ok = 1'b1;
        maddr = mif.mem_addr;
        for (int i = 0; i < 40 && !seen; i++) begin
            edges++;
            start = (i == poke_at);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mif.mem_rd === 1'b1) begin
                rd_cycles++;
                mif.mem_ready = (rd_cycles > delay);
            end else begin
                mif.mem_ready = 1'b0;
            end
            if (load_valid === 1'b1) begin
                seen = 1'b1;
                data = load_data;
                err  = load_err;
            end
            if (!seen) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        mif.mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (load_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", load_valid); end
        checks++; if (load_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", load_data); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b exp 0", load_err); end
        checks++; if (mif.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd got %b exp 0", mif.mem_rd); end
        checks++; if (mif.mem_addr !== 64'd0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h exp 0", mif.mem_addr); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_directed();
        bit seen; logic [63:0] data; logic err; logic [63:0] maddr;
        int rd; int edges; bit bok;
        logic [63:0] w = 64'h1122_3344_8855_6677;

        do_load(load_instr(3'd0), 64'h1003, w, 0, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL lb_seen got 0 exp 1"); end
        checks++; if (data !== 64'hFFFF_FFFF_FFFF_FF88) begin errors++; $display("[TB] FAIL lb_data got %h exp ffffffffffffff88", data); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL lb_err got %b exp 0", err); end
        checks++; if (maddr !== 64'h1000) begin errors++; $display("[TB] FAIL lb_mem_addr got %h exp 1000", maddr); end
        checks++; if (edges != 2) begin errors++; $display("[TB] FAIL lb_latency got %0d exp 2", edges); end

        do_load(load_instr(3'd4), 64'h1003, w, 0, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (data !== 64'h88) begin errors++; $display("[TB] FAIL lbu_data got %h exp 88", data); end
        do_load(load_instr(3'd5), 64'h1002, w, 0, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (data !== 64'h8855) begin errors++; $display("[TB] FAIL lhu_data got %h exp 8855", data); end
        do_load(load_instr(3'd6), 64'h1004, w, 0, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (data !== 64'h1122_3344) begin errors++; $display("[TB] FAIL lwu_data got %h exp 11223344", data); end

        do_load(load_instr(3'd2), 64'h1000, w, 5, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (data !== 64'hFFFF_FFFF_8855_6677) begin errors++; $display("[TB] FAIL lw_wait_data got %h exp ffffffff88556677", data); end
        checks++; if (rd != 6) begin errors++; $display("[TB] FAIL lw_wait_rd_cycles got %0d exp 6", rd); end
        checks++; if (!bok) begin errors++; $display("[TB] FAIL lw_wait_busy got dropped exp held"); end

        do_load(load_instr(3'd7), 64'h2000, w, 1, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err got %b exp 1", err); end
        checks++; if (data !== w) begin errors++; $display("[TB] FAIL illegal_data got %h exp %h", data, w); end
    endtask

    task automatic test_timeout();
        bit seen; logic [63:0] data; logic err; logic [63:0] maddr;
        int rd; int edges; bit bok;
        do_load(load_instr(3'd3), 64'h3000, 64'hDEAD_BEEF_0123_4567, 1000, 4,
                seen, data, err, maddr, rd, edges, bok);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL timeout_seen got 0 exp 1"); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got %b exp 1", err); end
        checks++; if (data !== 64'd0) begin errors++; $display("[TB] FAIL timeout_data got %h exp 0", data); end
        checks++; if (rd != 15) begin errors++; $display("[TB] FAIL timeout_rd_cycles got %0d exp 15", rd); end
        repeat (3) begin
            checks++;
            if (busy !== 1'b0 || mif.mem_rd !== 1'b0) begin
                errors++; $display("[TB] FAIL busy_start_ignored got busy=%b mem_rd=%b exp 0 0", busy, mif.mem_rd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_misalign();
        bit seen; logic [63:0] data; logic err; logic [63:0] maddr;
        int rd; int edges; bit bok;
        logic [63:0] exp_data; logic exp_err; bit trapped;
        logic [63:0] w = 64'hCAFE_F00D_8765_4321;
        ref_load(3'd2, 64'h1002, w, exp_data, exp_err, trapped);
        do_load(load_instr(3'd2), 64'h1002, w, 2, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL misalign_data got %h exp %h", data, exp_data); end
        checks++; if (err !== exp_err) begin errors++; $display("[TB] FAIL misalign_err got %b exp %b", err, exp_err); end
        checks++; if (rd != (trapped ? 0 : 3)) begin errors++; $display("[TB] FAIL misalign_rd_cycles got %0d exp %0d", rd, trapped ? 0 : 3); end
    endtask

    task automatic test_ignored_opcode();
        start = 1'b1;
        instr = {17'd0, 3'd3, 5'd1, 7'h23};
        addr  = 64'h4000;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || mif.mem_rd !== 1'b0) begin
            errors++; $display("[TB] FAIL ignored_opcode got busy=%b mem_rd=%b exp 0 0", busy, mif.mem_rd);
        end
    endtask

    task automatic test_reset_mid_load();
        bit valid_seen = 1'b0;
        start = 1'b1;
        instr = load_instr(3'd3);
        addr  = 64'h5000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mif.mem_rd !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid_load got mem_rd=%b busy=%b exp 0 0", mif.mem_rd, busy);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (5) begin
            if (load_valid === 1'b1) valid_seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (valid_seen) begin errors++; $display("[TB] FAIL reset_mid_load_valid got 1 exp 0"); end
    endtask

    task automatic test_random();
        bit seen; logic [63:0] data; logic err; logic [63:0] maddr;
        int rd; int edges; bit bok;
        logic [63:0] exp_data; logic exp_err; bit trapped;
        logic [2:0] f3; logic [63:0] a; logic [63:0] w; int delay;
        for (int n = 0; n < 40; n++) begin
            f3    = 3'($urandom_range(0, 7));
            a     = {$urandom, $urandom};
            w     = {$urandom, $urandom};
            delay = int'($urandom_range(0, 4));
            ref_load(f3, a, w, exp_data, exp_err, trapped);
            do_load(load_instr(f3), a, w, delay, -1, seen, data, err, maddr, rd, edges, bok);
            checks++;
            if (!seen || data !== exp_data || err !== exp_err) begin
                errors++;
                $display("[TB] FAIL random_load f3=%0d addr=%h got seen=%b data=%h err=%b exp data=%h err=%b",
                         f3, a, seen, data, err, exp_data, exp_err);
            end
            checks++;
            if (rd != (trapped ? 0 : delay + 1)) begin
                errors++; $display("[TB] FAIL random_rd_cycles got %0d exp %0d", rd, trapped ? 0 : delay + 1);
            end
            if (!trapped) begin
                checks++;
                if (maddr !== {a[63:3], 3'b000}) begin
                    errors++; $display("[TB] FAIL random_mem_addr got %h exp %h", maddr, {a[63:3], 3'b000});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen; logic [63:0] data; logic err; logic [63:0] maddr;
        int rd; int edges; bit bok;
        do_load(load_instr(3'd1), 64'h6006, 64'h8001_0000_0000_0000, 0, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (data !== 64'hFFFF_FFFF_FFFF_8001) begin errors++; $display("[TB] FAIL b2b_first got %h exp ffffffffffff8001", data); end
        do_load(load_instr(3'd3), 64'h7000, 64'h0123_4567_89AB_CDEF, 0, -1, seen, data, err, maddr, rd, edges, bok);
        checks++; if (data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("[TB] FAIL b2b_second got %h exp 0123456789abcdef", data); end
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 64'd0;
        test_reset();
        test_directed();
        test_timeout();
        test_misalign();
        test_ignored_opcode();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
